// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: frame sequencer for an RNN accelerator.
// A frame first streams NUM_SAMPLES host samples into SRAM with spaced write
// strobes, then replays them one at a time through the RNN cell, and finally
// raises an interrupt once the SRAM reports completion. A cell that fails to
// answer within CELL_TIMEOUT cycles parks the sequencer in a sticky error
// state that only reset can leave.
module rnn_seq_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_SAMPLES  = 500,
    parameter int CNT_W        = 9,
    parameter int WR_GAP       = 4,
    parameter int CELL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  host_valid,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ready,
    output logic                  sram_data_valid,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_read_start,
    input  logic                  sram_datafeed_en,
    input  logic                  sram_complete,
    output logic                  sram_int_clear,
    output logic                  cell_start,
    input  logic                  cell_done,
    output logic                  yhat_valid,
    output logic                  irq,
    input  logic                  irq_ack,
    output logic                  err,
    output logic                  busy,
    output logic [CNT_W-1:0]      sample_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_GAP,
        RD_START,
        WAIT_FEED,
        CELL_RUN,
        FEED_END,
        WAIT_CMPL,
        IRQ,
        ERROR
    } state_e;

    // One shared cycle timer serves both the write-gap wait and the cell
    // watchdog; it is wide enough for whichever bound is larger.
    localparam int TMR_MAX = (CELL_TIMEOUT > WR_GAP) ? CELL_TIMEOUT : WR_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    // A strobe lands in the first LOAD_GAP cycle and the next acceptance needs
    // one LOAD cycle, so WR_GAP-1 cycles in LOAD_GAP give strobe spacing WR_GAP.
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((WR_GAP > 1) ? WR_GAP - 2 : 0);
    // The timer reads 0 in the cycle cell_start is high, so the last cycle
    // allowed for cell_done is CELL_TIMEOUT-1; err shows CELL_TIMEOUT cycles on.
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'((CELL_TIMEOUT > 0) ? CELL_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

    state_e                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] sram_data_in_q, sram_data_in_d;
    logic                  sram_data_valid_q, sram_data_valid_d;
    logic                  sram_read_start_q, sram_read_start_d;
    logic                  sram_int_clear_q, sram_int_clear_d;
    logic                  cell_start_q, cell_start_d;
    logic                  yhat_valid_q, yhat_valid_d;
    logic                  irq_q, irq_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    assign cnt_inc = sample_cnt_q + CNT_W'(1);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d           = state_q;
        tmr_d             = '0;
        sample_cnt_d      = sample_cnt_q;
        sram_data_in_d    = sram_data_in_q;
        sram_data_valid_d = 1'b0;
        sram_read_start_d = 1'b0;
        sram_int_clear_d  = 1'b0;
        cell_start_d      = 1'b0;
        yhat_valid_d      = 1'b0;
        irq_d             = irq_q;
        err_d             = err_q;
        host_ready        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sample_cnt_d = '0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    sram_data_in_d    = host_data;
                    sram_data_valid_d = 1'b1;
                    state_d           = LOAD_GAP;
                end
            end
            LOAD_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    sample_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        sram_read_start_d = 1'b1;
                        state_d           = RD_START;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RD_START: begin
                sample_cnt_d = '0;
                state_d      = WAIT_FEED;
            end
            WAIT_FEED: begin
                if (sram_datafeed_en) begin
                    cell_start_d = 1'b1;
                    state_d      = CELL_RUN;
                end
            end
            CELL_RUN: begin
                // A result arriving on the last permitted cycle beats the watchdog.
                if (cell_done) begin
                    yhat_valid_d = 1'b1;
                    state_d      = FEED_END;
                end else if (tmr_q == TO_LAST) begin
                    err_d   = 1'b1;
                    irq_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            FEED_END: begin
                if (!sram_datafeed_en) begin
                    sample_cnt_d = cnt_inc;
                    state_d      = (cnt_inc == CNT_LAST) ? WAIT_CMPL : WAIT_FEED;
                end
            end
            WAIT_CMPL: begin
                if (sram_complete) begin
                    irq_d   = 1'b1;
                    state_d = IRQ;
                end
            end
            IRQ: begin
                if (irq_ack) begin
                    sram_int_clear_d = 1'b1;
                    irq_d            = 1'b0;
                    state_d          = IDLE;
                end
            end
            ERROR: begin
                irq_d = 1'b1;
                err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and every registered output, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            tmr_q             <= '0;
            sample_cnt_q      <= '0;
            sram_data_in_q    <= '0;
            sram_data_valid_q <= 1'b0;
            sram_read_start_q <= 1'b0;
            sram_int_clear_q  <= 1'b0;
            cell_start_q      <= 1'b0;
            yhat_valid_q      <= 1'b0;
            irq_q             <= 1'b0;
            err_q             <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop load from the
            // pre-edge values, independent of statement order.
            state_q           <= state_d;
            tmr_q             <= tmr_d;
            sample_cnt_q      <= sample_cnt_d;
            sram_data_in_q    <= sram_data_in_d;
            sram_data_valid_q <= sram_data_valid_d;
            sram_read_start_q <= sram_read_start_d;
            sram_int_clear_q  <= sram_int_clear_d;
            cell_start_q      <= cell_start_d;
            yhat_valid_q      <= yhat_valid_d;
            irq_q             <= irq_d;
            err_q             <= err_d;
            busy_q            <= busy_d;
        end
    end

    assign sram_data_valid = sram_data_valid_q;
    assign sram_data_in    = sram_data_in_q;
    assign sram_read_start = sram_read_start_q;
    assign sram_int_clear  = sram_int_clear_q;
    assign cell_start      = cell_start_q;
    assign yhat_valid      = yhat_valid_q;
    assign irq             = irq_q;
    assign err             = err_q;
    assign busy            = busy_q;
    assign sample_cnt      = sample_cnt_q;

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// tb_rnn_seq_ctrl: directed frames for rnn_seq_ctrl with an event-level
// scoreboard. The monitor knows only what each event must carry (strobe i
// writes the i-th accepted host word, the k-th cell launch happens at index k,
// pulses are single-cycle, strobes are at least WR_GAP apart); the stimulus
// pins exact values such as reset state, interrupt handshakes and the
// watchdog cycle.
module tb_rnn_seq_ctrl;

    localparam int DATA_WIDTH   = 16;
    localparam int NUM_SAMPLES  = 500;
    localparam int CNT_W        = 9;
    localparam int WR_GAP       = 4;
    localparam int CELL_TIMEOUT = 255;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  host_valid;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  host_ready;
    logic                  sram_data_valid;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic                  sram_read_start;
    logic                  sram_datafeed_en;
    logic                  sram_complete;
    logic                  sram_int_clear;
    logic                  cell_start;
    logic                  cell_done;
    logic                  yhat_valid;
    logic                  irq;
    logic                  irq_ack;
    logic                  err;
    logic                  busy;
    logic [CNT_W-1:0]      sample_cnt;

    rnn_seq_ctrl #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_SAMPLES (NUM_SAMPLES),
        .CNT_W       (CNT_W),
        .WR_GAP      (WR_GAP),
        .CELL_TIMEOUT(CELL_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .host_valid      (host_valid),
        .host_data       (host_data),
        .host_ready      (host_ready),
        .sram_data_valid (sram_data_valid),
        .sram_data_in    (sram_data_in),
        .sram_read_start (sram_read_start),
        .sram_datafeed_en(sram_datafeed_en),
        .sram_complete   (sram_complete),
        .sram_int_clear  (sram_int_clear),
        .cell_start      (cell_start),
        .cell_done       (cell_done),
        .yhat_valid      (yhat_valid),
        .irq             (irq),
        .irq_ack         (irq_ack),
        .err             (err),
        .busy            (busy),
        .sample_cnt      (sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input integer act, input integer exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- model
    int                    cyc           = 0;
    int                    last_strobe   = 0;
    bit                    has_strobe    = 1'b0;
    int                    strobes_f     = 0;
    int                    strobes_total = 0;
    int                    cs_f          = 0;
    int                    ys_f          = 0;
    int                    rs_f          = 0;
    logic [DATA_WIDTH-1:0] exp_din       = '0;
    logic [DATA_WIDTH-1:0] acc_q[$];
    logic [4:0]            prev_pls      = '0;

    // Compare process: runs on the falling edge, away from the active edge.
    initial begin
        logic [4:0] pls;
        forever begin
            @(negedge clk);
            cyc++;
            pls = {sram_data_valid, sram_read_start, cell_start, yhat_valid, sram_int_clear};
            if (!rst_n) begin
                acc_q.delete();
                exp_din    = '0;
                has_strobe = 1'b0;
                strobes_f  = 0;
                cs_f       = 0;
                ys_f       = 0;
                rs_f       = 0;
                prev_pls   = '0;
            end else begin
                if (!busy) begin
                    has_strobe = 1'b0;
                    strobes_f  = 0;
                    cs_f       = 0;
                    ys_f       = 0;
                    rs_f       = 0;
                end
                check("cnt_bound", 32'(sample_cnt <= CNT_W'(NUM_SAMPLES)), 1);
                if (|pls) check("pulse_width", 32'(pls & prev_pls), 0);
                prev_pls = pls;
                if (busy && has_strobe && (cyc - last_strobe) < WR_GAP - 1)
                    check("ready_in_gap", 32'(host_ready), 0);
                if (sram_data_valid) begin
                    check("strobe_has_src", 32'(acc_q.size() > 0), 1);
                    if (acc_q.size() > 0) exp_din = acc_q.pop_front();
                    check("cnt_at_strobe", 32'(sample_cnt), strobes_f);
                    if (has_strobe) check("strobe_gap", 32'((cyc - last_strobe) >= WR_GAP), 1);
                    has_strobe  = 1'b1;
                    last_strobe = cyc;
                    strobes_f++;
                    strobes_total++;
                end
                check("sram_data_in", 32'(sram_data_in), 32'(exp_din));
                if (host_ready && host_valid) begin
                    check("cnt_at_accept", 32'(sample_cnt), strobes_f);
                    acc_q.push_back(host_data);
                end
                if (sram_read_start) begin
                    check("strobes_before_rd", strobes_f, NUM_SAMPLES);
                    rs_f++;
                end
                if (cell_start) begin
                    check("cnt_at_cell_start", 32'(sample_cnt), cs_f);
                    check("cell_order", ys_f, cs_f);
                    cs_f++;
                end
                if (yhat_valid) begin
                    check("cnt_at_yhat", 32'(sample_cnt), ys_f);
                    check("yhat_order", cs_f, ys_f + 1);
                    ys_f++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("ready_after_start", 32'(host_ready), 1);
        check("cnt_after_start", 32'(sample_cnt), 0);
    endtask

    task automatic run_load(input int n, input int base);
        int idx = 0;
        int g   = 0;
        bit acc;
        host_valid = 1'b1;
        host_data  = DATA_WIDTH'(base);
        while (idx < n && g < n * WR_GAP * 2 + 20) begin
            acc = host_ready;
            tick();
            g++;
            if (acc) begin
                idx++;
                host_data = DATA_WIDTH'(base + idx);
            end
        end
        host_valid = 1'b0;
        check("load_accepts", idx, n);
    endtask

    task automatic wait_rd();
        int g = 0;
        while (!sram_read_start && g < 4 * WR_GAP + 8) begin
            tick();
            g++;
        end
        check("rd_start_seen", 32'(sram_read_start), 1);
        check("cnt_at_rd_start", 32'(sample_cnt), NUM_SAMPLES);
        check("strobes_in_frame", strobes_f, NUM_SAMPLES);
        tick();
        check("rd_start_width", 32'(sram_read_start), 0);
        check("cnt_cleared_rd", 32'(sample_cnt), 0);
    endtask

    task automatic run_read(input int long_idx, input int long_dly, input int hold_idx);
        int g;
        int dly;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            sram_datafeed_en = 1'b1;
            g = 0;
            while (!cell_start && g < 10) begin
                tick();
                g++;
            end
            if (!cell_start) begin
                check("cell_start_seen", 32'(cell_start), 1);
                sram_datafeed_en = 1'b0;
                return;
            end
            if (i == hold_idx) begin
                repeat (CELL_TIMEOUT - 1) tick();
                check("err_before_to", 32'(err), 0);
                check("irq_before_to", 32'(irq), 0);
                tick();
                check("err_at_to", 32'(err), 1);
                check("irq_at_to", 32'(irq), 1);
                irq_ack = 1'b1;
                repeat (3) tick();
                irq_ack = 1'b0;
                check("err_ack_ignored", 32'(err), 1);
                check("irq_ack_ignored", 32'(irq), 1);
                check("clear_in_error", 32'(sram_int_clear), 0);
                check("busy_in_error", 32'(busy), 1);
                sram_datafeed_en = 1'b0;
                return;
            end
            dly = (i == long_idx) ? long_dly : 3;
            repeat (dly) tick();
            cell_done = 1'b1;
            tick();
            cell_done = 1'b0;
            check("yhat_after_done", 32'(yhat_valid), 1);
            if (i == long_idx) check("err_done_wins", 32'(err), 0);
            sram_datafeed_en = 1'b0;
            tick();
        end
    endtask

    task automatic finish_frame();
        check("cnt_end_read", 32'(sample_cnt), NUM_SAMPLES);
        check("irq_before_cmpl", 32'(irq), 0);
        sram_complete = 1'b1;
        tick();
        sram_complete = 1'b0;
        check("irq_after_cmpl", 32'(irq), 1);
        check("busy_in_irq", 32'(busy), 1);
        check("cell_starts_frame", cs_f, NUM_SAMPLES);
        check("yhats_frame", ys_f, NUM_SAMPLES);
        check("rd_starts_frame", rs_f, 1);
        repeat (2) tick();
        check("irq_held", 32'(irq), 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("int_clear_pulse", 32'(sram_int_clear), 1);
        check("irq_cleared", 32'(irq), 0);
        check("busy_after_ack", 32'(busy), 0);
        tick();
        check("int_clear_width", 32'(sram_int_clear), 0);
    endtask

    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1;
        check("rst_err", 32'(err), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        #3 rst_n = 1'b1;
        tick();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int snap;
        rst_n            = 1'b0;
        start            = 1'b0;
        host_valid       = 1'b0;
        host_data        = '0;
        sram_datafeed_en = 1'b0;
        sram_complete    = 1'b0;
        cell_done        = 1'b0;
        irq_ack          = 1'b0;
        #3;
        check("reset_outs", 32'({host_ready, sram_data_valid, sram_read_start, sram_int_clear,
                                 cell_start, yhat_valid, irq, err, busy}), 0);
        check("reset_data", 32'(sram_data_in), 0);
        check("reset_cnt", 32'(sample_cnt), 0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("idle_not_busy", 32'(busy), 0);

        // Frame 1: nominal frame, cell answers 3 cycles after each launch.
        start_frame();
        run_load(NUM_SAMPLES, 0);
        wait_rd();
        run_read(-1, 0, -1);
        finish_frame();

        // Stray cell_done / irq_ack while idle change nothing.
        cell_done = 1'b1;
        irq_ack   = 1'b1;
        repeat (2) tick();
        cell_done = 1'b0;
        irq_ack   = 1'b0;
        check("idle_stray_outs", 32'({irq, yhat_valid, sram_int_clear, busy, cell_start, err}), 0);
        check("idle_cnt_kept", 32'(sample_cnt), NUM_SAMPLES);

        // Frame 2: start held during load, strays in LOAD, one sample answered
        // on the very last cycle before the watchdog would fire.
        start = 1'b1;
        tick();
        check("busy_frame2", 32'(busy), 1);
        check("cnt_frame2", 32'(sample_cnt), 0);
        cell_done = 1'b1;
        irq_ack   = 1'b1;
        repeat (2) tick();
        cell_done = 1'b0;
        irq_ack   = 1'b0;
        check("load_stray_outs", 32'({sram_data_valid, yhat_valid, sram_int_clear, irq}), 0);
        check("load_stray_ready", 32'(host_ready), 1);
        check("load_stray_cnt", 32'(sample_cnt), 0);
        run_load(NUM_SAMPLES, 0);
        start = 1'b0;
        wait_rd();
        run_read(3, CELL_TIMEOUT - 1, -1);
        finish_frame();

        // Frame 3: cell never answers sample 7.
        start_frame();
        run_load(NUM_SAMPLES, 0);
        wait_rd();
        run_read(-1, 0, 7);
        reset_now();

        // Frame 4: reset in the middle of loading sample 200.
        start_frame();
        run_load(201, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({host_ready, sram_data_valid, sram_read_start, sram_int_clear,
                                     cell_start, yhat_valid, irq, err, busy}), 0);
        check("async_rst_data", 32'(sram_data_in), 0);
        check("async_rst_cnt", 32'(sample_cnt), 0);
        host_valid = 1'b1;
        repeat (2) tick();
        #3 rst_n = 1'b1;
        snap = strobes_total;
        repeat (20) tick();
        check("no_strobe_after_rst", strobes_total, snap);
        check("idle_after_rst", 32'({busy, host_ready}), 0);
        start_frame();
        run_load(3, 77);
        tick();
        check("strobes_after_restart", strobes_total, snap + 3);
        check("data_after_restart", 32'(sram_data_in), 79);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/rnn_seq_ctrl.md
RNN_SEQ_CTRL -- requirements
Module: rnn_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter NUM_SAMPLES, default 500, samples per frame.
REQ-003 SHALL have parameter CNT_W, default 9, sample counter width.
REQ-004 SHALL have parameter WR_GAP, default 4, minimum cycles between SRAM write strobes.
REQ-005 SHALL have parameter CELL_TIMEOUT, default 255, maximum cycles from cell_start to cell_done.
REQ-006 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have these remaining ports (name, direction, width, meaning):
- start, in, 1, begin a frame.
- host_valid, in, 1, host sample available.
- host_data, in, DATA_WIDTH, host sample.
- host_ready, out, 1, host sample accepted this cycle.
- sram_data_valid, out, 1, SRAM write strobe.
- sram_data_in, out, DATA_WIDTH, SRAM write data.
- sram_read_start, out, 1, SRAM read-phase start.
- sram_datafeed_en, in, 1, SRAM sample presented.
- sram_complete, in, 1, SRAM frame done.
- sram_int_clear, out, 1, SRAM completion clear.
- cell_start, out, 1, RNN cell launch pulse.
- cell_done, in, 1, RNN cell result ready.
- yhat_valid, out, 1, prediction valid pulse, also routed to the SRAM.
- irq, out, 1, frame-done or error interrupt.
- irq_ack, in, 1, host interrupt acknowledge.
- err, out, 1, sticky cell timeout flag.
- busy, out, 1, high when the FSM is not in IDLE.
- sample_cnt, out, CNT_W, current sample index.

Function
REQ-009 SHALL implement these FSM states: IDLE, LOAD, LOAD_GAP, RD_START, WAIT_FEED, CELL_RUN, FEED_END, WAIT_CMPL, IRQ, ERROR.
REQ-010 IDLE: on start=1, SHALL clear sample_cnt to 0 and go to LOAD; start SHALL be ignored in every other state.
REQ-011 LOAD: host_ready=1 combinationally; on host_valid=1 SHALL register host_data into sram_data_in, pulse sram_data_valid for 1 cycle (next cycle), and go to LOAD_GAP.
REQ-012 sram_data_in SHALL hold its value until the next host acceptance.
REQ-013 LOAD_GAP: SHALL wait so that strobes are spaced at least WR_GAP cycles apart; SHALL then increment sample_cnt, go to RD_START if the new count equals NUM_SAMPLES, else go to LOAD.
REQ-014 RD_START: SHALL clear sample_cnt, hold sram_read_start=1, and go to WAIT_FEED after 1 cycle.
REQ-015 WAIT_FEED: on sram_datafeed_en=1, SHALL pulse cell_start for 1 cycle and go to CELL_RUN.
REQ-016 CELL_RUN: SHALL count cycles since cell_start; on cell_done=1, SHALL pulse yhat_valid for 1 cycle and go to FEED_END; if the count reaches CELL_TIMEOUT without cell_done, SHALL set err=1 and go to ERROR.
REQ-017 If cell_done and timeout occur in the same cycle, cell_done SHALL win.
REQ-018 FEED_END: SHALL wait for sram_datafeed_en=0, then increment sample_cnt; go to WAIT_CMPL if the count equals NUM_SAMPLES, else go to WAIT_FEED.
REQ-019 WAIT_CMPL: on sram_complete=1, SHALL set irq=1 and go to IRQ.
REQ-020 IRQ: irq held at 1; on irq_ack=1, SHALL pulse sram_int_clear for 1 cycle, clear irq, and go to IDLE.
REQ-021 ERROR: irq=1 and err=1 SHALL be held; irq_ack SHALL be ignored; only reset SHALL exit this state.
REQ-022 All outputs except host_ready SHALL be registered.
REQ-023 All pulse outputs SHALL be exactly 1 cycle wide.
REQ-024 sample_cnt arithmetic SHALL be unsigned CNT_W-bit and SHALL never exceed NUM_SAMPLES.
REQ-025 cell_done outside CELL_RUN SHALL be ignored.
REQ-026 irq_ack outside IRQ/ERROR SHALL be ignored.

Reset
REQ-027 While rst_n=0, SHALL force: state IDLE; all outputs 0, including sram_data_in=0, sample_cnt=0, err=0, irq=0, busy=0; all internal counters 0.
REQ-028 Assertion of rst_n mid-frame SHALL abort the frame immediately, with no further strobes after release until start.

Verification
REQ-029 Reset, then start, then 500 back-to-back host_valid samples (value i): exactly 500 sram_data_valid pulses; strobe spacing >= 4 cycles; sram_data_in=i on strobe i; host_ready low in LOAD_GAP; one sram_read_start pulse follows.
REQ-030 Read phase with cell_done 3 cycles after each cell_start: 500 cell_start pulses and 500 yhat_valid pulses; sample_cnt reaches 500; irq=1 after sram_complete.
REQ-031 In IRQ, assert irq_ack: sram_int_clear is 1 for 1 cycle; irq=0; busy=0 the next cycle; a second start runs a full second frame.
REQ-032 Withhold cell_done for sample 7: err=1 and irq=1 exactly 255 cycles after cell_start; irq_ack has no effect; rst_n clears both.
REQ-033 cell_done on the timeout cycle: yhat_valid pulses, err stays 0. Stray cell_done and irq_ack in IDLE/LOAD: no output change.
REQ-034 rst_n low during sample 200 of load: all outputs 0 asynchronously; no strobes after release until start.
